// File: rtl/serial_frame_deser.sv
// serial_frame_deser: hunts for a sync word in a strobed serial bit stream,
// then deserializes fixed-size data words and re-checks sync after every
// FRAMES_PER_SYNC data words. Completed words go out over valid/ready.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   bit_en       sample strobe; bit_in is consumed only when high
//   bit_in       serial data, MSB first
//   frame_data   assembled data word
//   frame_valid  frame_data holds an unconsumed word
//   frame_ready  downstream accept (effective only while frame_valid=1)
//   locked       high while in LOCK or CHECK
//   overrun      one-cycle pulse when a completed word is dropped
//   sync_err     one-cycle pulse when a sync check fails
module serial_frame_deser #(
  parameter int unsigned      WIDTH           = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD       = WIDTH'(8'hA5),
  parameter int unsigned      FRAMES_PER_SYNC = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             locked,
  output logic             overrun,
  output logic             sync_err
);

  localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned FCW = $clog2(FRAMES_PER_SYNC + 1);

  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [FCW-1:0] FPS_CNT  = FCW'(FRAMES_PER_SYNC);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [FCW-1:0]   framecnt_q, framecnt_d;
  logic [WIDTH-1:0] frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             locked_q, locked_d;
  logic             overrun_q, overrun_d;
  logic             sync_err_q, sync_err_d;

  logic [WIDTH-1:0] shreg_shift;
  logic [FCW-1:0]   framecnt_inc;
  logic             word_done;

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      framecnt_q    <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      overrun_q     <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      framecnt_q    <= framecnt_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      locked_q      <= locked_d;
      overrun_q     <= overrun_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // Next-state, framing and handshake logic
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bitcnt_d      = bitcnt_q;
    framecnt_d    = framecnt_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = 1'b0;
    sync_err_d    = 1'b0;
    word_done     = 1'b0;
    shreg_shift   = {shreg_q[WIDTH-2:0], bit_in};
    framecnt_inc  = framecnt_q + FCW'(1);

    // Acceptance frees the holding register; a word completing this same
    // cycle reloads it below, giving back-to-back transfer with no bubble.
    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    if (bit_en) begin
      shreg_d = shreg_shift;
      unique case (state_q)
        ST_HUNT: begin
          if (shreg_shift == SYNC_WORD) begin
            state_d    = ST_LOCK;
            bitcnt_d   = '0;
            framecnt_d = '0;
          end
        end
        ST_LOCK: begin
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d  = '0;
            word_done = 1'b1;
            if (framecnt_inc == FPS_CNT) begin
              state_d    = ST_CHECK;
              framecnt_d = '0;
            end else begin
              framecnt_d = framecnt_inc;
            end
          end else begin
            bitcnt_d = bitcnt_q + BCW'(1);
          end
        end
        ST_CHECK: begin
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            // The sync word itself is never forwarded downstream.
            if (shreg_shift == SYNC_WORD) begin
              state_d = ST_LOCK;
            end else begin
              // HUNT restarts from the current shreg for bit-level realignment.
              state_d    = ST_HUNT;
              sync_err_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + BCW'(1);
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    // A word completing while the old one is still pending is dropped.
    if (word_done) begin
      if (!frame_valid_q || frame_ready) begin
        frame_data_d  = shreg_shift;
        frame_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    locked_d = (state_d != ST_HUNT);
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign overrun     = overrun_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser with FRAMES_PER_SYNC=2.
module tb_serial_frame_deser;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic         bit_en;
  logic         bit_in;
  logic [W-1:0] frame_data;
  logic         frame_valid;
  logic         frame_ready;
  logic         locked;
  logic         overrun;
  logic         sync_err;

  int n_checks;
  int n_fail;

  // Observation log filled on the falling edge
  int           cyc;
  logic [W-1:0] acc_mem [0:63];
  int           acc_cyc [0:63];
  int           acc_n;
  int           ov_cnt;
  int           se_cnt;
  int           vld_cnt;

  serial_frame_deser #(
    .WIDTH(8),
    .SYNC_WORD(8'hA5),
    .FRAMES_PER_SYNC(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bit_en(bit_en),
    .bit_in(bit_in),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .locked(locked),
    .overrun(overrun),
    .sync_err(sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    cyc = 0; acc_n = 0; ov_cnt = 0; se_cnt = 0; vld_cnt = 0;
  end

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (frame_valid && frame_ready) begin
        acc_mem[acc_n[5:0]] <= frame_data;
        acc_cyc[acc_n[5:0]] <= cyc;
        acc_n <= acc_n + 1;
      end
      if (overrun)     ov_cnt  <= ov_cnt + 1;
      if (sync_err)    se_cnt  <= se_cnt + 1;
      if (frame_valid) vld_cnt <= vld_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_en = 1'b1;
    bit_in = b;
    @(posedge clock); #1;
    bit_en = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  int a0, o0, s0, v0;
  logic [7:0] a5;

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; bit_en = 1'b0; bit_in = 1'b0; frame_ready = 1'b0;
    a5 = 8'hA5;
    idle(2);

    // Reset state
    check("rst_data",  32'(frame_data),  32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_locked", 32'(locked),     32'h0);
    check("rst_flags", 32'({overrun, sync_err}), 32'h0);
    reset = 1'b0;
    idle(1);

    // Junk then sync, bit_en every 2nd clock
    send_byte(8'h3C, 1);
    for (int i = 7; i >= 1; i--) send_bit(a5[i], 1);
    check("pre_lock", 32'(locked), 32'h0);
    bit_en = 1'b1; bit_in = a5[0];
    @(posedge clock); #1;
    bit_en = 1'b0;
    check("lock_rise", 32'(locked), 32'h1);
    check("lock_novalid", 32'(frame_valid), 32'h0);
    idle(1);

    // Data words with frame_ready=1
    frame_ready = 1'b1;
    a0 = acc_n; s0 = se_cnt; v0 = vld_cnt;
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'hA5, 1);
    send_byte(8'h56, 1);
    idle(3);
    check("data_cnt", 32'(acc_n - a0), 32'd3);
    check("data_w0", 32'(acc_mem[a0]),     32'h12);
    check("data_w1", 32'(acc_mem[a0 + 1]), 32'h34);
    check("data_w2", 32'(acc_mem[a0 + 2]), 32'h56);
    check("data_vld_cycles", 32'(vld_cnt - v0), 32'd3);
    check("data_no_serr", 32'(se_cnt - s0), 32'd0);
    check("data_locked", 32'(locked), 32'h1);

    // Back-pressure and overrun
    do_reset();
    frame_ready = 1'b0;
    a0 = acc_n; o0 = ov_cnt;
    send_byte(8'hA5, 1);
    send_byte(8'h11, 1);
    check("bp_valid_0", 32'(frame_valid), 32'h1);
    check("bp_no_ov_yet", 32'(ov_cnt - o0), 32'd0);
    send_byte(8'h22, 1);
    idle(2);
    check("bp_overrun", 32'(ov_cnt - o0), 32'd1);
    check("bp_hold_data", 32'(frame_data), 32'h11);
    check("bp_hold_valid", 32'(frame_valid), 32'h1);
    frame_ready = 1'b1;
    idle(2);
    check("bp_acc_cnt", 32'(acc_n - a0), 32'd1);
    check("bp_acc_word", 32'(acc_mem[a0]), 32'h11);
    check("bp_valid_drop", 32'(frame_valid), 32'h0);

    // Sync loss and realignment
    do_reset();
    frame_ready = 1'b1;
    a0 = acc_n; s0 = se_cnt;
    send_byte(8'hA5, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    send_byte(8'hC3, 1);
    idle(2);
    check("sl_serr", 32'(se_cnt - s0), 32'd1);
    check("sl_unlocked", 32'(locked), 32'h0);
    check("sl_acc_cnt", 32'(acc_n - a0), 32'd2);
    check("sl_w0", 32'(acc_mem[a0]),     32'hAA);
    check("sl_w1", 32'(acc_mem[a0 + 1]), 32'hBB);
    send_byte(8'hA5, 1);
    check("sl_relock", 32'(locked), 32'h1);
    send_byte(8'h77, 1);
    idle(2);
    check("sl_post_word", 32'(acc_mem[a0 + 2]), 32'h77);

    // Reset asserted mid-frame
    do_reset();
    frame_ready = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    check("mf_pre_valid", 32'(frame_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mf_async_clear", 32'({frame_data, frame_valid, locked, overrun, sync_err}), 32'h0);
    idle(1);
    reset = 1'b0;
    idle(1);
    frame_ready = 1'b1;
    a0 = acc_n;
    send_byte(8'h12, 1);
    idle(2);
    check("mf_no_word", 32'(acc_n - a0), 32'd0);
    check("mf_unlocked", 32'(locked), 32'h0);
    send_byte(8'hA5, 1);
    send_byte(8'h34, 1);
    idle(2);
    check("mf_fresh_word", 32'(acc_mem[a0]), 32'h34);

    // Back-to-back with bit_en continuously high
    do_reset();
    frame_ready = 1'b1;
    a0 = acc_n; v0 = vld_cnt; s0 = se_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'hA5, 0);
    idle(3);
    check("b2b_cnt", 32'(acc_n - a0), 32'd2);
    check("b2b_w0", 32'(acc_mem[a0]),     32'h01);
    check("b2b_w1", 32'(acc_mem[a0 + 1]), 32'h02);
    check("b2b_spacing", 32'(acc_cyc[a0 + 1] - acc_cyc[a0]), 32'd8);
    check("b2b_vld_cycles", 32'(vld_cnt - v0), 32'd2);
    check("b2b_no_serr", 32'(se_cnt - s0), 32'd0);
    check("b2b_locked", 32'(locked), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
